// File: rtl/sym_vn_lut_loader.sv
// sym_vn_lut_loader: reloads a two-bank LUT from an upstream entry stream.
// Entries arrive in pairs (bank0 first, then bank1). Each pair is written with
// one we pulse to a 7-bit address {write_addr_offset, page_write_addr} that
// walks 0..127 once per load.
module sym_vn_lut_loader #(
  parameter int QUAN_SIZE    = 4,
  parameter int PAGE_ADDR_BW = 6
) (
  input  logic                    write_clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [QUAN_SIZE-1:0]    entry_in,
  input  logic                    entry_valid,
  output logic                    entry_ready,
  output logic [QUAN_SIZE-1:0]    lut_in_bank0,
  output logic [QUAN_SIZE-1:0]    lut_in_bank1,
  output logic [PAGE_ADDR_BW-1:0] page_write_addr,
  output logic                    write_addr_offset,
  output logic                    we,
  output logic                    busy,
  output logic                    load_done
);

  localparam int ADDR_BW = PAGE_ADDR_BW + 1;

  typedef enum logic [2:0] {
    IDLE,
    GET_B0,
    GET_B1,
    WRITE,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ADDR_BW-1:0] addr;
  logic               last_addr;

  // The page-half select is the MSB of the linear write address.
  assign {write_addr_offset, page_write_addr} = addr;
  assign last_addr = &addr;

  // State register with synchronous reset.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: GET states hold until a valid entry arrives.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (load_start)  state_next = GET_B0;
      GET_B0:  if (entry_valid) state_next = GET_B1;
      GET_B1:  if (entry_valid) state_next = WRITE;
      WRITE:   state_next = last_addr ? DONE : GET_B0;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    entry_ready = 1'b0;
    we          = 1'b0;
    busy        = 1'b0;
    load_done   = 1'b0;
    unique case (state)
      GET_B0, GET_B1: begin
        entry_ready = 1'b1;
        busy        = 1'b1;
      end
      WRITE: begin
        we   = 1'b1;
        busy = 1'b1;
      end
      DONE:    load_done = 1'b1;
      default: ;
    endcase
  end

  // Entry capture and write-address sequencing.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      lut_in_bank0 <= '0;
      lut_in_bank1 <= '0;
      addr         <= '0;
    end else begin
      unique case (state)
        IDLE:   if (load_start)  addr <= '0;
        GET_B0: if (entry_valid) lut_in_bank0 <= entry_in;
        GET_B1: if (entry_valid) lut_in_bank1 <= entry_in;
        WRITE:  if (!last_addr)  addr <= addr + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
